// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: round-robin burst arbiter for the VGA frame-buffer write port (optional vblank gating: VRAM_ARB_VBLANK_GATE_EN)
module vram_write_arbiter #(
    parameter int AW        = 15,
    parameter int DW        = 12,
    parameter int DEPTH     = 20000,
    parameter int MAX_BURST = 64
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [2:0]      req,
    input  logic [2:0]      valid,
    input  logic [3*AW-1:0] addr_flat,
    input  logic [3*DW-1:0] data_flat,
    input  logic            vblank,
    output logic [2:0]      gnt,
    output logic            vwe,
    output logic [AW-1:0]   vaddr,
    output logic [DW-1:0]   vdata,
    output logic            preempt,
    output logic [7:0]      drop_cnt
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);
    localparam logic [7:0]  MB    = 8'(MAX_BURST);
    state_t        state;
    logic [1:0]    owner, last_owner, first, second, pick;
    logic [7:0]    beats, beats_nxt;
    logic [AW-1:0] oaddr;
    logic [DW-1:0] odata;
    logic          in_grant, legal, accept, bad, hit_max, drop_req, gate_ok, gate_kill;
    logic [2:0]    stray;
    logic [8:0]    dsum;
`ifdef VRAM_ARB_VBLANK_GATE_EN
    assign gate_ok   = vblank;
    assign gate_kill = !vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign gate_ok       = 1'b1;
    assign gate_kill     = 1'b0;
`endif
    // Round-robin pick, owner beat legality and drop accounting
    always_comb begin
        first     = (last_owner == 2'd2) ? 2'd0 : last_owner + 2'd1;
        second    = (first == 2'd2) ? 2'd0 : first + 2'd1;
        pick      = req[first] ? first : req[second] ? second : last_owner;
        oaddr     = addr_flat[owner*AW +: AW];
        odata     = data_flat[owner*DW +: DW];
        in_grant  = state == GRANT;
        legal     = {1'b0, oaddr} < LIMIT;
        accept    = in_grant && valid[owner] && legal;
        bad       = in_grant && valid[owner] && !legal;
        stray     = valid & ~gnt;
        dsum      = {1'b0, drop_cnt} + 9'(stray[0]) + 9'(stray[1]) + 9'(stray[2]) + 9'(bad);
        beats_nxt = beats + 8'(accept);
        hit_max   = accept && beats_nxt == MB;
        drop_req  = !req[owner];
    end
    // Grant FSM with registered write port, preempt pulse and saturating drop counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            gnt        <= '0;
            vwe        <= 1'b0;
            vaddr      <= '0;
            vdata      <= '0;
            preempt    <= 1'b0;
            drop_cnt   <= '0;
            owner      <= 2'd0;
            last_owner <= 2'd2;
            beats      <= '0;
        end else begin
            vwe      <= accept;
            preempt  <= 1'b0;
            drop_cnt <= dsum[8] ? 8'hff : dsum[7:0];
            if (accept) begin
                vaddr <= oaddr;
                vdata <= odata;
            end
            case (state)
                IDLE: if (|req && gate_ok) begin
                    owner <= pick;
                    gnt   <= 3'b001 << pick;
                    beats <= '0;
                    state <= GRANT;
                end
                GRANT: begin
                    beats <= beats_nxt;
                    if (drop_req || hit_max || gate_kill) begin
                        state      <= GAP;
                        gnt        <= '0;
                        last_owner <= owner;
                        preempt    <= !drop_req;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb_vram_write_arbiter: scoreboard bench for vram_write_arbiter (VRAM_ARB_VBLANK_GATE_EN selects the vblank scenario)
module tb_vram_write_arbiter;
    localparam int AW = 15;
    localparam int DW = 12;
    logic            clk = 1'b0, nrst = 1'b0, vblank = 1'b1;
    logic [2:0]      req = '0, valid = '0;
    logic [3*AW-1:0] addr_flat = '0;
    logic [3*DW-1:0] data_flat = '0;
    logic [2:0]      gnt, prev_gnt = '0;
    logic            vwe, preempt;
    logic [AW-1:0]   vaddr;
    logic [DW-1:0]   vdata;
    logic [7:0]      drop_cnt;
    int              vectors = 0, miscompares = 0;
    logic [AW+DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    vram_write_arbiter dut (
        .clk(clk), .nrst(nrst), .req(req), .valid(valid), .addr_flat(addr_flat),
        .data_flat(data_flat), .vblank(vblank), .gnt(gnt), .vwe(vwe), .vaddr(vaddr),
        .vdata(vdata), .preempt(preempt), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input int i, input int a, input int d, input bit expect_write);
        valid[i] = 1'b1;
        addr_flat[i*AW +: AW] = AW'(a);
        data_flat[i*DW +: DW] = DW'(d);
        if (expect_write) exp_q.push_back({AW'(a), DW'(d)});
    endtask

    // Scoreboard monitor: every write must match the oldest expected beat
    always @(negedge clk) begin
        if (nrst && vwe) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected write: addr %0d data %0h, none expected", vaddr, vdata);
            end else chk("write addr/data", {vaddr, vdata}, exp_q.pop_front());
            chk("vwe after live grant", 32'(prev_gnt != 3'b000), 1);
            chk("gnt onehot", 32'($onehot0(gnt)), 1);
        end
        prev_gnt = gnt;
    end

    task automatic rr_burst(input int o, input int base);
        for (int k = 0; k < 4; k++) begin
            beat(o, base + k, base + k + o * 16, 1'b1);
            if (k == 3) req[o] = 1'b0;
            step(1);
        end
        valid = '0;
        chk("rr release gnt", 32'(gnt), 0);
        req[o] = 1'b1;
        step(1);
        chk("rr idle gnt", 32'(gnt), 0);
        step(1);
    endtask

    initial begin
        #1;
        chk("reset gnt", 32'(gnt), 0);
        chk("reset vwe", 32'(vwe), 0);
        chk("reset drop", 32'(drop_cnt), 0);
        step(2);
        nrst = 1'b1;
        // async reset in the middle of a burst
        req = 3'b001;
        step(1);
        chk("first grant", 32'(gnt), 32'b001);
        beat(0, 5, 'hab, 1'b1);
        step(1);
        @(negedge clk);
        #1;
        chk("vwe before reset", 32'(vwe), 1);
        nrst = 1'b0;
        #1;
        chk("async gnt", 32'(gnt), 0);
        chk("async vwe", 32'(vwe), 0);
        chk("async vaddr", 32'(vaddr), 0);
        chk("async vdata", 32'(vdata), 0);
        req = '0;
        valid = '0;
        @(posedge clk);
        #1 nrst = 1'b1;
        req = 3'b100;
        step(1);
        chk("post-reset grant", 32'(gnt), 32'b100);
        req = '0;
        step(2);
        // round robin 0,1,2,0 with 4 beats each
        req = 3'b111;
        step(1);
        for (int r = 0; r < 4; r++) begin
            chk("rr grant", 32'(gnt), 32'(3'b001 << (r % 3)));
            rr_burst(r % 3, 100 * r);
        end
        chk("rr wrap grant", 32'(gnt), 32'b010);
        req = '0;
        step(2);
        // illegal address and non-owner beat
        chk("drop before illegal", 32'(drop_cnt), 0);
        req = 3'b001;
        step(1);
        chk("illegal grant", 32'(gnt), 32'b001);
        beat(0, 19999, 'h123, 1'b1);
        step(1);
        beat(0, 20000, 'h456, 1'b0);
        step(1);
        chk("drop after 20000", 32'(drop_cnt), 1);
        chk("vwe after 20000", 32'(vwe), 0);
        valid = 3'b100;
        step(1);
        chk("drop after stray", 32'(drop_cnt), 2);
        chk("vwe after stray", 32'(vwe), 0);
        valid = '0;
        req = '0;
        step(2);
        // saturation with no owner
        valid = 3'b010;
        step(100);
        chk("drop at 102", 32'(drop_cnt), 102);
        step(153);
        chk("drop at 255", 32'(drop_cnt), 255);
        step(47);
        chk("drop holds 255", 32'(drop_cnt), 255);
        valid = '0;
        // forced release at 64 beats
        req = 3'b010;
        step(1);
        chk("burst grant", 32'(gnt), 32'b010);
        for (int k = 0; k < 64; k++) begin
            beat(1, 1000 + k, k, 1'b1);
            step(1);
            if (k == 62) chk("no early preempt", 32'(preempt), 0);
            if (k == 62) chk("gnt before max", 32'(gnt), 32'b010);
        end
        chk("preempt pulse", 32'(preempt), 1);
        chk("gnt after max", 32'(gnt), 0);
        beat(1, 2000, 1, 1'b0);
        step(1);
        chk("preempt one cycle", 32'(preempt), 0);
        chk("no write after max", 32'(vwe), 0);
        req = '0;
        valid = '0;
        step(2);
`ifdef VRAM_ARB_VBLANK_GATE_EN
        vblank = 1'b0;
        req = 3'b010;
        step(3);
        chk("gated no grant", 32'(gnt), 0);
        vblank = 1'b1;
        step(1);
        chk("vblank grant", 32'(gnt), 32'b010);
        beat(1, 7, 7, 1'b1);
        step(1);
        valid = '0;
        vblank = 1'b0;
        step(1);
        chk("vblank release gnt", 32'(gnt), 0);
        chk("vblank preempt", 32'(preempt), 1);
`else
        vblank = 1'b0;
        req = 3'b100;
        step(1);
        chk("ungated grant", 32'(gnt), 32'b100);
`endif
        req = '0;
        valid = '0;
        step(3);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
